// File: rtl/lsu_dmem_port.sv
// Load/store initiator: turns byte/halfword/word loads and stores into word
// accesses on a single-port data memory, using read-modify-write for SB/SH.
module lsu_dmem_port #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_din,
  input  logic [XLEN-1:0]   mem_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state;
  logic              we_p0;
  logic [2:0]        funct3_p0;
  logic [ADDR_W+1:0] addr_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [XLEN-1:0]   merge_p1;

  // Address bits above the memory's word range are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[XLEN-1:ADDR_W+2];

  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [1:0] off);
    logic illegal;
    logic misal;
    if (we) illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else    illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misal = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    return illegal || misal;
  endfunction

  function automatic logic [XLEN-1:0] load_fmt(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic [XLEN-1:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [XLEN-1:0]    r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = XLEN'(b);
      3'b001:  r = XLEN'(h);
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] store_merge(input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] r;
    r = old;
    case (f3)
      3'b000:  r[{off, 3'b000} +: 8] = wd[7:0];
      3'b001:  if (off[1]) r[31:16] = wd[15:0];
               else        r[15:0]  = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // A reset landing in WR must kill that edge's write immediately.
  assign mem_we     = (state == WR) && !rst;
  assign mem_addr   = (state == IDLE) ? '0 : addr_p0[ADDR_W+1:2];
  assign mem_din    = (state == WR) ? store_merge(funct3_p0, addr_p0[1:0], merge_p1, wdata_p0)
                                    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_p0      <= 1'b0;
      funct3_p0  <= '0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      merge_p1   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_p0      <= req_we;
          funct3_p0  <= req_funct3;
          addr_p0    <= req_addr[ADDR_W+1:0];
          wdata_p0   <= req_wdata;
          resp_rdata <= '0;
          if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
            resp_err <= 1'b1;
            state    <= RESP;
          end else begin
            resp_err <= 1'b0;
            state    <= (req_we && req_funct3 == 3'b010) ? WR : RD;
          end
        end
        // Sub-word stores fetch the old word; loads format it into the response.
        RD: begin
          if (we_p0) begin
            merge_p1 <= mem_dout;
            state    <= WR;
          end else begin
            resp_rdata <= load_fmt(funct3_p0, addr_p0[1:0], mem_dout);
            state      <= RESP;
          end
        end
        WR: state <= RESP;
        default: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port: behavioural word memory plus a response
// scoreboard checked when resp_valid fires.
module tb_lsu_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_din, mem_dout;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  lsu_dmem_port #(.ADDR_W(10), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_din;
    else if (pl_en) mem[pl_a]     <= pl_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1 pl_en = 1'b0;
    @(negedge clk);
  endtask

  // Issue one request, then watch the DUT cycle by cycle until its response.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e, input logic [31:0] rd, input int lat,
                        input int exp_wk, input logic [31:0] exp_wd);
    exp_t x;
    int   wr_n, wr_k, lat_seen;
    logic [31:0] wr_d;
    x.err = e; x.rdata = rd; x.lat = lat;
    sbq.push_back(x);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    wr_n = 0; wr_k = 0; wr_d = '0; lat_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1 && !e) chk({tag, " mem_addr"}, {22'b0, mem_addr}, {22'b0, a[11:2]});
      if (mem_we) begin wr_n++; wr_k = k; wr_d = mem_din; end
      if (resp_valid) begin lat_seen = k; break; end
    end
    x = sbq.pop_front();
    chk({tag, " latency"}, lat_seen, x.lat);
    chk({tag, " err"}, {31'b0, resp_err}, {31'b0, x.err});
    chk({tag, " rdata"}, resp_rdata, x.rdata);
    chk({tag, " writes"}, wr_n, (exp_wk != 0) ? 1 : 0);
    if (exp_wk != 0) begin
      chk({tag, " wr_cycle"}, wr_k, exp_wk);
      chk({tag, " wr_data"}, wr_d, exp_wd);
    end
    @(negedge clk);
    chk({tag, " back_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst mem_din", mem_din, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", {31'b0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    preload(10'd4, 32'hDEAD_BEEF);
    do_req("LW",      1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 32'h0);
    do_req("LW hiaddr", 1'b0, 3'b010, 32'hFFFF_F010, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 32'h0);

    preload(10'd4, 32'h80FF_0000);
    do_req("LB",  1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0, 32'h0);
    do_req("LBU", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 2, 0, 32'h0);
    do_req("LH",  1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_80FF, 2, 0, 32'h0);
    do_req("LHU", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_80FF, 2, 0, 32'h0);
    do_req("LB2", 1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 32'hFFFF_FFFF, 2, 0, 32'h0);
    do_req("LH0", 1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'h0000_0000, 2, 0, 32'h0);

    preload(10'd4, 32'h1122_3344);
    do_req("SB", 1'b1, 3'b000, 32'h11, 32'h0000_00AB, 1'b0, 32'h0, 3, 2, 32'h1122_AB44);
    chk("SB mem", mem[4], 32'h1122_AB44);

    preload(10'd5, 32'hAABB_CCDD);
    do_req("SH", 1'b1, 3'b001, 32'h16, 32'h1234_BEEF, 1'b0, 32'h0, 3, 2, 32'hBEEF_CCDD);
    chk("SH mem", mem[5], 32'hBEEF_CCDD);

    do_req("SW0", 1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1, 32'hCAFE_F00D);
    chk("SW0 mem", mem[0], 32'hCAFE_F00D);

    do_req("LW misal",  1'b0, 3'b010, 32'h6,  32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
    do_req("f3 011",    1'b0, 3'b011, 32'h0,  32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
    do_req("SH misal",  1'b1, 3'b001, 32'h21, 32'hFFFF, 1'b1, 32'h0, 1, 0, 32'h0);
    do_req("S f3 100",  1'b1, 3'b100, 32'h20, 32'hFF, 1'b1, 32'h0, 1, 0, 32'h0);
    chk("err no write", mem[8], 32'hx);

    // Reset arriving while an SH sits in WR.
    preload(10'd8, 32'h1122_3344);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'h5566;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstWR in WR", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1 chk("rstWR mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    chk("rstWR ready", {31'b0, req_ready}, 32'd1);
    chk("rstWR resp", {31'b0, resp_valid}, 32'd0);
    chk("rstWR mem", mem[8], 32'h1122_3344);
    rst = 1'b0;
    @(negedge clk);
    chk("rstWR resp2", {31'b0, resp_valid}, 32'd0);
    do_req("SW after", 1'b1, 3'b010, 32'h8, 32'h0000_1234, 1'b0, 32'h0, 2, 1, 32'h0000_1234);
    chk("SW after mem", mem[2], 32'h0000_1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_port.md
Name: lsu_dmem_port

Overview:
- Load/store initiator that drives the word-wide data memory from the datapath side.
- Converts RISC-V byte, halfword and word loads/stores into word accesses.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Detects misaligned and illegal accesses and reports them without touching memory.

Parameters:
- ADDR_W, 10, word-address width of the data memory (1024 words).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (state==IDLE)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data (low bytes used for SB/SH)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  XLEN  formatted load data (0 for stores/errors)
- resp_err  out  1  misaligned or illegal funct3, valid with resp_valid
- mem_addr  out  ADDR_W  word address to data memory
- mem_we  out  1  memory write enable
- mem_din  out  XLEN  write data to memory
- mem_dout  in  XLEN  combinational read data from memory

Behaviour:
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_din=0.
  - All latched request registers are cleared to 0.
- Accept: in IDLE, req_valid=1 latches we, funct3, addr, wdata. req_valid is ignored in any other state.
- Word index = addr[ADDR_W+1:2]. Higher address bits are ignored.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- States: IDLE, RD, WR, RESP.
- Transitions (request accepted at edge ending cycle N):
  - Illegal or misaligned: IDLE→RESP. Cycle N+1: resp_valid=1, resp_err=1, resp_rdata=0; no memory write.
  - Load: IDLE→RD(N+1)→RESP(N+2)→IDLE.
    - RD: mem_addr=word index, mem_we=0. mem_dout is selected by addr[1:0], extended, and registered into resp_rdata.
  - SW: IDLE→WR(N+1)→RESP(N+2)→IDLE.
    - WR: mem_we=1, mem_din=wdata.
  - SB/SH: IDLE→RD(N+1)→WR(N+2)→RESP(N+3)→IDLE.
    - RD captures mem_dout into merge register.
    - WR writes the merged word; only the addressed byte/halfword lane is replaced, other lanes are preserved.
  - RESP: resp_valid=1 for exactly one cycle; req_ready=0. Next state is always IDLE, so back-to-back requests are spaced by at least the sequence latency.
- Lane select:
  - Byte lane = addr[1:0] (bits [8k+7:8k]).
  - Halfword lane = addr[1] (bits [15:0] or [31:16]).
- Extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW returns the word unchanged.
- mem_we is 1 only in state WR and only when rst=0. A reset asserted during WR suppresses that write.
- mem_addr holds the latched word index in RD/WR/RESP and is 0 in IDLE. mem_din is 0 outside WR.
- Reset in any state returns to IDLE on the next edge; no response is issued for the aborted request.
- Stores to word 0 are issued normally. The memory's own handling of its externally driven word is outside this block.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → req_ready=1, resp_valid=0, mem_we=0, mem_addr=0.
- LW at 0x0000_0010, mem word 4 = 0xDEAD_BEEF → mem_addr=4 in N+1; resp_valid at N+2 with resp_rdata=0xDEAD_BEEF, resp_err=0.
- LB/LBU at 0x13, word 4 = 0x80FF_0000 → LB returns 0xFFFF_FF80; LBU returns 0x0000_0080. LH at 0x12 returns 0xFFFF_80FF.
- SB at 0x11, wdata=0x0000_00AB, word 4 = 0x1122_3344 → mem_we=1 only in N+2 with mem_din=0x1122_AB44; resp_valid at N+3.
- Misaligned LW at 0x0000_0006 and illegal funct3=011 → resp_valid at N+1 with resp_err=1, mem_we never asserted.
- rst asserted during WR of an SH → no write at that edge (mem_we=0), state IDLE, no resp_valid; a following SW at 0x8 with 0x0000_1234 completes normally.
